sync_fifo_prog: RTL and testbench



---
 rtl/sync_fifo_prog.sv | 90 +++++++++
 tb/tb_sync_fifo_prog.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth >= 2, runtime almost-full/almost-empty thresholds,
// a read-data valid strobe, and write-through-while-full when a read is taken in the same cycle.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CW-1:0]         af_level,
  input  logic [CW-1:0]         ae_level,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap at FIFO_DEPTH-1, not at the binary boundary, so odd depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign rd_acc = rd_en && (count_q != '0);
  assign wr_acc = wr_en && ((count_q != DEPTH_C) || rd_acc);

  // Storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr   <= ptr_next(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      rd_valid  <= rd_acc;
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  // Status flags follow the current occupancy and thresholds without lookahead.
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_level) && !full;
  assign almostempty = (count_q <= ae_level) && !empty;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog at depth 5, width 8: fill, overflow, write-through
// while full, pointer wrap, write on empty with read, threshold changes and reset mid-run.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [CW-1:0] af_level;
  logic [CW-1:0] ae_level;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          wr_ack;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          almostfull;
  logic          empty;
  logic          almostempty;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  sync_fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_level(af_level), .ae_level(ae_level), .data_out(data_out),
    .rd_valid(rd_valid), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .almostfull(almostfull),
    .empty(empty), .almostempty(almostempty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one clock edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_rd [5];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    af_level = 3'd4; ae_level = 3'd1;
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almostfull, 0);
    chk("rst_ae", almostempty, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_flags", {wr_ack, overflow, underflow, rd_valid}, 0);
    rst = 1'b0;

    // Fill with 0x11..0x55
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = DW'((i + 1) * 8'h11);
      step();
      chk("fill_ack", wr_ack, 1);
      chk("fill_count", count, i + 1);
      chk("fill_af", almostfull, (i == 3) ? 1 : 0);
      chk("fill_full", full, (i == 4) ? 1 : 0);
      chk("fill_ae", almostempty, (i == 0) ? 1 : 0);
    end

    // Write while full, no read: rejected
    wr_en = 1'b1; rd_en = 1'b0; data_in = 8'h66;
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_count", count, 5);

    // Write while full with read: pass-through
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h66;
    step();
    chk("wt_ack", wr_ack, 1);
    chk("wt_rdv", rd_valid, 1);
    chk("wt_dout", data_out, 8'h11);
    chk("wt_count", count, 5);
    chk("wt_ovf", overflow, 0);

    // Drain: wr_ptr must have wrapped for 0x66 to appear last
    exp_rd[0] = 8'h22; exp_rd[1] = 8'h33; exp_rd[2] = 8'h44;
    exp_rd[3] = 8'h55; exp_rd[4] = 8'h66;
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_dout", data_out, exp_rd[i]);
      chk("drain_rdv", rd_valid, 1);
      chk("drain_count", count, 4 - i);
    end
    chk("drain_empty", empty, 1);

    // Empty: read and write together, only the write is taken
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hA5;
    step();
    chk("ew_unf", underflow, 1);
    chk("ew_ack", wr_ack, 1);
    chk("ew_rdv", rd_valid, 0);
    chk("ew_count", count, 1);
    chk("ew_ae", almostempty, 1);
    chk("ew_hold", data_out, 8'h66);
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk("ew_dout", data_out, 8'hA5);
    chk("ew_rdv2", rd_valid, 1);
    chk("ew_count2", count, 0);

    // Thresholds at count 3
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = DW'(i + 1);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("th_count", count, 3);
    chk("th_af_before", almostfull, 0);
    chk("th_ae_before", almostempty, 0);
    af_level = 3'd3;
    #1;
    chk("th_af_after", almostfull, 1);
    ae_level = 3'd3;
    #1;
    chk("th_ae_after", almostempty, 1);

    // Reset mid-operation overrides requests
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
    step();
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_flags", {wr_ack, overflow, underflow, rd_valid}, 0);
    chk("mrst_dout", data_out, 0);

    // Plain underflow on empty
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk("unf_flag", underflow, 1);
    chk("unf_rdv", rd_valid, 0);
    rd_en = 1'b0;
    step();
    chk("unf_clear", underflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
